// File: rtl/act_sparse_reader_pkg.sv
// Shared constants and FSM encoding for the sparse activation reader.
package act_sparse_reader_pkg;

  localparam int PE_ACT_NO_DEFAULT     = 16;
  localparam int PE_DATA_WIDTH_DEFAULT = 16;

  typedef enum logic {
    ACT_IDLE = 1'b0,
    ACT_SCAN = 1'b1
  } act_state_e;

endpackage

// File: rtl/act_out_fifo.sv
// Two-entry output FIFO with fall-through: an arriving element is presented
// the same cycle when the FIFO is empty, and is stored only if not taken.
module act_out_fifo #(
  parameter int AW = 4,
  parameter int DW = 16
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          flush,
  input  logic          push,
  input  logic [AW-1:0] push_idx,
  input  logic [DW-1:0] push_data,
  input  logic          push_last,
  input  logic          out_ready,
  output logic          out_valid,
  output logic [AW-1:0] out_idx,
  output logic [DW-1:0] out_data,
  output logic          out_last,
  output logic [1:0]    count
);

  localparam int EW = AW + DW + 1;

  logic [EW-1:0] mem [2];
  logic [1:0]    count_reg;
  logic          wr_ptr_reg;
  logic          rd_ptr_reg;
  logic [EW-1:0] push_entry;
  logic [EW-1:0] head_entry;
  logic          bypass;
  logic          pop;
  logic          store;
  logic          drop;

  assign push_entry = {push_idx, push_data, push_last};
  assign bypass     = (count_reg == 2'd0);
  assign out_valid  = !bypass || push;
  assign pop        = out_valid && out_ready;
  assign store      = push && !(bypass && pop);
  assign drop       = pop && !bypass;
  // Outputs are forced to zero when nothing is presented.
  assign head_entry = !out_valid ? '0 : (bypass ? push_entry : mem[rd_ptr_reg]);
  assign {out_idx, out_data, out_last} = head_entry;
  assign count      = count_reg;

  always_ff @(posedge clk) begin
    if (store && !flush) begin
      mem[wr_ptr_reg] <= push_entry;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_reg  <= 2'd0;
      wr_ptr_reg <= 1'b0;
      rd_ptr_reg <= 1'b0;
    end else if (flush) begin
      count_reg  <= 2'd0;
      wr_ptr_reg <= 1'b0;
      rd_ptr_reg <= 1'b0;
    end else begin
      count_reg <= count_reg + {1'b0, store} - {1'b0, drop};
      if (store) wr_ptr_reg <= ~wr_ptr_reg;
      if (drop)  rd_ptr_reg <= ~rd_ptr_reg;
    end
  end

endmodule

// File: rtl/act_sparse_reader.sv
// Scans a snapshot of nonzero activation flags, reads each nonzero entry
// lowest index first, and streams (idx, data, last) over valid/ready.
module act_sparse_reader
  import act_sparse_reader_pkg::*;
#(
  parameter int PE_ACT_NO = PE_ACT_NO_DEFAULT,
  parameter int DW        = PE_DATA_WIDTH_DEFAULT,
  parameter int AW        = $clog2(PE_ACT_NO)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic                 abort,
  input  logic [PE_ACT_NO-1:0] in_act_zeros,
  output logic                 in_act_read_en,
  output logic [AW-1:0]        in_act_read_addr,
  input  logic [DW-1:0]        in_act_read_data,
  output logic                 act_valid,
  input  logic                 act_ready,
  output logic [AW-1:0]        act_idx,
  output logic [DW-1:0]        act_data,
  output logic                 act_last,
  output logic                 busy,
  output logic                 done
);

  act_state_e           state_reg;
  logic [PE_ACT_NO-1:0] pending_reg;
  logic                 inflight_reg;
  logic [AW-1:0]        inflight_idx_reg;
  logic                 inflight_last_reg;
  logic                 done_reg;

  logic [1:0]           fifo_count;
  logic [AW-1:0]        sel_idx;
  logic [PE_ACT_NO-1:0] sel_mask;
  logic [PE_ACT_NO-1:0] pending_after;
  logic                 has_pending;
  logic                 pop;
  logic                 room;
  logic                 issue;
  logic                 scan_complete;

  always_comb begin
    sel_idx = '0;
    for (int i = PE_ACT_NO - 1; i >= 0; i--) begin
      if (pending_reg[i]) sel_idx = AW'(i);
    end
  end

  assign sel_mask      = pending_reg & (~pending_reg + PE_ACT_NO'(1));
  assign pending_after = pending_reg & ~sel_mask;
  assign has_pending   = |pending_reg;
  assign pop           = act_valid && act_ready;
  // Never let stored + in-flight elements exceed the two FIFO slots.
  assign room          = ({1'b0, fifo_count} + {2'b00, inflight_reg}) <= (3'd1 + {2'b00, pop});
  assign issue         = (state_reg == ACT_SCAN) && !abort && has_pending && room;
  assign scan_complete = (state_reg == ACT_SCAN) && !has_pending && !inflight_reg
                         && (fifo_count == 2'd0);

  assign in_act_read_en   = issue;
  assign in_act_read_addr = issue ? sel_idx : '0;
  assign busy             = (state_reg == ACT_SCAN);
  assign done             = done_reg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg         <= ACT_IDLE;
      pending_reg       <= '0;
      inflight_reg      <= 1'b0;
      inflight_idx_reg  <= '0;
      inflight_last_reg <= 1'b0;
      done_reg          <= 1'b0;
    end else begin
      done_reg     <= 1'b0;
      inflight_reg <= issue;
      if (issue) begin
        pending_reg       <= pending_after;
        inflight_idx_reg  <= sel_idx;
        inflight_last_reg <= (pending_after == '0);
      end
      if (abort) begin
        state_reg    <= ACT_IDLE;
        pending_reg  <= '0;
        inflight_reg <= 1'b0;
      end else begin
        case (state_reg)
          ACT_IDLE: begin
            if (start) begin
              state_reg   <= ACT_SCAN;
              pending_reg <= ~in_act_zeros;
            end
          end
          ACT_SCAN: begin
            if (scan_complete) begin
              state_reg <= ACT_IDLE;
              done_reg  <= 1'b1;
            end
          end
          default: state_reg <= ACT_IDLE;
        endcase
      end
    end
  end

  act_out_fifo #(
    .AW(AW),
    .DW(DW)
  ) u_out_fifo (
    .clk      (clk),
    .rst_n    (rst_n),
    .flush    (abort),
    .push     (inflight_reg),
    .push_idx (inflight_idx_reg),
    .push_data(in_act_read_data),
    .push_last(inflight_last_reg),
    .out_ready(act_ready),
    .out_valid(act_valid),
    .out_idx  (act_idx),
    .out_data (act_data),
    .out_last (act_last),
    .count    (fifo_count)
  );

endmodule
